// File: rtl/led_scan_controller.sv
// ============================================================================
// Module      : led_scan_controller
// Description : Four-digit multiplexed LED scanner with double-buffered
//               character data, per-digit blanking and frame-aligned commit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_scan_controller #(
    parameter int TICK_DIV  = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] data_in,
    output logic        ready,
    output logic        commit,
    output logic [3:0]  AN,
    output logic [3:0]  char,
    output logic [1:0]  digit
);

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_BLANK = 2'd1;
    localparam logic [1:0]  c_SHOW  = 2'd2;

    localparam logic [15:0] c_TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [15:0] c_BLANK_LAST = 16'(BLANK_CYC - 1);
    localparam logic        c_HAS_BLANK  = (BLANK_CYC != 0);
    localparam logic [1:0]  c_DIGIT_HEAD = c_HAS_BLANK ? c_BLANK : c_SHOW;

    logic [15:0] r_shadow;
    logic [15:0] r_display;
    logic        r_pending;
    logic        r_ready;
    logic        r_commit;
    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [1:0]  r_digit;
    logic [3:0]  r_an;
    logic [3:0]  r_char;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [1:0]  w_digit_nxt;
    logic        w_enter_show0;
    logic        w_commit;
    logic        w_load_ok;
    logic        w_pending_nxt;
    logic [15:0] w_display_nxt;
    logic [3:0]  w_an_nxt;
    logic [3:0]  w_char_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_digit_nxt = r_digit;
        if (!enable) begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = 16'd0;
            w_digit_nxt = 2'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_state_nxt = c_DIGIT_HEAD;
                    w_cnt_nxt   = 16'd0;
                    w_digit_nxt = 2'd0;
                end
                c_BLANK: begin
                    if (r_cnt == c_BLANK_LAST) begin
                        w_state_nxt = c_SHOW;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                c_SHOW: begin
                    if (r_cnt == c_TICK_LAST) begin
                        w_state_nxt = c_DIGIT_HEAD;
                        w_cnt_nxt   = 16'd0;
                        w_digit_nxt = r_digit + 2'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 16'd0;
                    w_digit_nxt = 2'd0;
                end
            endcase
        end
    end

    // Staying inside an ongoing digit-0 SHOW is not an entry; only the first edge counts.
    assign w_enter_show0 = (w_state_nxt == c_SHOW) && (w_digit_nxt == 2'd0) &&
                           !((r_state == c_SHOW) && (r_digit == 2'd0));
    assign w_commit      = r_pending && ((r_state == c_IDLE) || w_enter_show0);
    assign w_load_ok     = load && r_ready;
    assign w_pending_nxt = w_load_ok ? 1'b1 : (w_commit ? 1'b0 : r_pending);
    assign w_display_nxt = w_commit ? r_shadow : r_display;

    // Outputs are registered from next-state values so they line up with the state they describe.
    assign w_an_nxt   = (w_state_nxt == c_SHOW) ? ~(4'b0001 << w_digit_nxt) : 4'b1111;
    assign w_char_nxt = (w_state_nxt == c_IDLE) ? 4'd0
                                                : w_display_nxt[{w_digit_nxt, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow  <= 16'd0;
            r_display <= 16'd0;
            r_pending <= 1'b0;
            r_ready   <= 1'b1;
            r_commit  <= 1'b0;
            r_state   <= c_IDLE;
            r_cnt     <= 16'd0;
            r_digit   <= 2'd0;
            r_an      <= 4'b1111;
            r_char    <= 4'd0;
        end else begin
            if (w_load_ok) begin
                r_shadow <= data_in;
            end
            r_display <= w_display_nxt;
            r_pending <= w_pending_nxt;
            r_ready   <= !w_pending_nxt;
            r_commit  <= w_commit;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_digit   <= w_digit_nxt;
            r_an      <= w_an_nxt;
            r_char    <= w_char_nxt;
        end
    end

    assign ready  = r_ready;
    assign commit = r_commit;
    assign AN     = r_an;
    assign char   = r_char;
    assign digit  = r_digit;

endmodule

`default_nettype wire

// File: tb/tb_led_scan_controller.sv
// ============================================================================
// Module      : tb_led_scan_controller
// Description : Directed self-checking bench for led_scan_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_scan_controller;

    logic        clk = 1'b0;
    logic        reset, enable, load, enable1, load1;
    logic [15:0] data_in;
    logic        ready, commit, ready1, commit1;
    logic [3:0]  an, chr, an1, chr1;
    logic [1:0]  digit, digit1;

    int errors = 0;
    int checks = 0;
    int pos0   = 0;
    int pos1   = 0;

    always #5 clk = ~clk;

    led_scan_controller #(.TICK_DIV(4), .BLANK_CYC(1)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .data_in(data_in),
        .ready(ready), .commit(commit), .AN(an), .char(chr), .digit(digit)
    );

    led_scan_controller #(.TICK_DIV(4), .BLANK_CYC(0)) dut1 (
        .clk(clk), .reset(reset), .enable(enable1), .load(load1), .data_in(data_in),
        .ready(ready1), .commit(commit1), .AN(an1), .char(chr1), .digit(digit1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {AN, char, digit} at a frame position for TICK_DIV=4.
    function automatic logic [9:0] exp_out(input int pos, input int blank, input logic [15:0] dv);
        int seg;
        int d;
        int r;
        logic [3:0] a;
        logic [3:0] c;
        seg = 4 + blank;
        d   = pos / seg;
        r   = pos % seg;
        a   = (r >= blank) ? ~(4'b0001 << d) : 4'b1111;
        c   = dv[4*d +: 4];
        return {a, c, d[1:0]};
    endfunction

    task automatic step0(input logic [15:0] dv);
        tick();
        pos0 = (pos0 + 1) % 20;
        chk($sformatf("scan0_pos%0d", pos0), {22'd0, an, chr, digit}, {22'd0, exp_out(pos0, 1, dv)});
    endtask

    task automatic step1(input logic [15:0] dv);
        tick();
        pos1 = (pos1 + 1) % 16;
        chk($sformatf("scan1_pos%0d", pos1), {22'd0, an1, chr1, digit1}, {22'd0, exp_out(pos1, 0, dv)});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; enable1 = 1'b0; load1 = 1'b0; data_in = 16'h0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_char", {28'd0, chr}, 32'h0);
        chk("rst_digit", {30'd0, digit}, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'h1);
        chk("rst_commit", {31'd0, commit}, 32'h0);

        // Idle load and commit
        load = 1'b1; data_in = 16'h3210;
        tick();
        load = 1'b0;
        chk("idle_ready_low", {31'd0, ready}, 32'h0);
        chk("idle_no_commit_yet", {31'd0, commit}, 32'h0);
        tick();
        chk("idle_commit", {31'd0, commit}, 32'h1);
        chk("idle_ready_back", {31'd0, ready}, 32'h1);
        tick();
        chk("idle_commit_pulse_end", {31'd0, commit}, 32'h0);
        chk("idle_char_off", {28'd0, chr}, 32'h0);

        // Two full frames of scanning
        enable = 1'b1;
        pos0 = 19;
        repeat (40) step0(16'h3210);

        // Mid-frame load during SHOW digit 2, plus an ignored second load
        repeat (12) step0(16'h3210);
        load = 1'b1; data_in = 16'hABCD;
        step0(16'h3210);
        load = 1'b0;
        chk("mid_ready_low", {31'd0, ready}, 32'h0);
        repeat (2) step0(16'h3210);
        load = 1'b1; data_in = 16'hFFFF;
        step0(16'h3210);
        load = 1'b0;
        chk("ignored_ready_low", {31'd0, ready}, 32'h0);
        chk("no_commit_midframe", {31'd0, commit}, 32'h0);
        repeat (5) step0(16'h3210);
        step0(16'hABCD);
        chk("frame_commit", {31'd0, commit}, 32'h1);
        chk("frame_commit_ready", {31'd0, ready}, 32'h1);
        step0(16'hABCD);
        chk("frame_commit_end", {31'd0, commit}, 32'h0);
        repeat (19) step0(16'hABCD);

        // Enable dropped during SHOW digit 1
        repeat (6) step0(16'hABCD);
        enable = 1'b0;
        tick();
        chk("dis_an", {28'd0, an}, 32'hF);
        chk("dis_digit", {30'd0, digit}, 32'h0);
        chk("dis_char", {28'd0, chr}, 32'h0);
        tick();
        chk("dis_hold_an", {28'd0, an}, 32'hF);
        enable = 1'b1;
        pos0 = 19;
        repeat (6) step0(16'hABCD);

        // Reset while a load is pending, reset overriding load/enable
        load = 1'b1; data_in = 16'h1234;
        tick();
        load = 1'b0;
        chk("pend_ready_low", {31'd0, ready}, 32'h0);
        reset = 1'b1; load = 1'b1; data_in = 16'h5555;
        tick();
        reset = 1'b0; load = 1'b0; enable = 1'b0;
        chk("rst2_an", {28'd0, an}, 32'hF);
        chk("rst2_char", {28'd0, chr}, 32'h0);
        chk("rst2_digit", {30'd0, digit}, 32'h0);
        chk("rst2_ready", {31'd0, ready}, 32'h1);
        chk("rst2_commit", {31'd0, commit}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst2_no_commit", {31'd0, commit}, 32'h0);
        end
        enable = 1'b1;
        pos0 = 19;
        repeat (6) step0(16'h0000);
        enable = 1'b0;

        // BLANK_CYC=0 instance: no blanking, 16-cycle frame
        load1 = 1'b1; data_in = 16'h7654;
        tick();
        load1 = 1'b0;
        chk("nb_ready_low", {31'd0, ready1}, 32'h0);
        tick();
        chk("nb_commit", {31'd0, commit1}, 32'h1);
        enable1 = 1'b1;
        pos1 = 15;
        repeat (32) step1(16'h7654);
        enable1 = 1'b0;
        tick();
        chk("nb_off_an", {28'd0, an1}, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
